// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM with one-cycle read latency.
// Round-robin by default; define ONCHIP_ARB_FIXED_PRIO_EN to give m0 fixed priority instead.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0, req1, gnt0, gnt1, rd_acc;
  logic rd_vld_p1, rd_own_p1;
`ifndef ONCHIP_ARB_FIXED_PRIO_EN
  logic prio1_p1;
`endif

  // Stage p0: combinational grant from current requests
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    gnt0 = ~reset & req0;
    gnt1 = ~reset & req1 & ~req0;
`else
    gnt0 = ~reset & req0 & (~req1 | ~prio1_p1);
    gnt1 = ~reset & req1 & (~req0 | prio1_p1);
`endif
    // A strobed write overrides a simultaneous read strobe
    rd_acc = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
  end

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
    mem_chipselect   = gnt0 | gnt1;
    mem_clken        = ~reset;
    m0_waitrequest   = reset | (req0 & ~gnt0);
    m1_waitrequest   = reset | (req1 & ~gnt1);
    m0_readdatavalid = ~reset & rd_vld_p1 & ~rd_own_p1;
    m1_readdatavalid = ~reset & rd_vld_p1 & rd_own_p1;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
  end

  // Stage p1: pending-read owner, aligned with mem_readdata
  always_ff @(posedge clk) begin
    if (reset) rd_vld_p1 <= 1'b0;
    else       rd_vld_p1 <= rd_acc;
  end

  always_ff @(posedge clk) begin
    rd_own_p1 <= gnt1;
  end

`ifndef ONCHIP_ARB_FIXED_PRIO_EN
  // prio1 set means m1 wins the next contention; moves only on an accepted request
  always_ff @(posedge clk) begin
    if (reset)             prio1_p1 <= 1'b0;
    else if (gnt0 | gnt1)  prio1_p1 <= gnt0;
  end
`endif

endmodule
